// File: rtl/mnist_seg_pkg.sv
// Shared types, palette and class decode for the MNIST segmentation overlay stage.
package mnist_seg_pkg;

    localparam int unsigned CLASS_NUM = 10;
    localparam int unsigned RGB_WIDTH = 24;

    typedef logic [3:0] class_t;

    typedef struct packed {
        logic   hit;
        class_t cls;
    } decode_t;

    localparam logic [RGB_WIDTH-1:0] PALETTE [CLASS_NUM] = '{
        24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'hFF00FF,
        24'h00FFFF, 24'hFF8000, 24'h8000FF, 24'h00FF80, 24'hFFFFFF
    };

    // Lowest set flag wins; background pixels never produce a hit.
    function automatic decode_t class_decode(input logic fg, input logic [CLASS_NUM-1:0] flags);
        decode_t d;
        d.hit = 1'b0;
        d.cls = '0;
        if (fg) begin
            for (int i = CLASS_NUM - 1; i >= 0; i--) begin
                if (flags[i]) begin
                    d.hit = 1'b1;
                    d.cls = class_t'(i);
                end
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/mnist_seg_class_counter.sv
// Per-class saturating pixel counters, published and restarted on each start-of-frame beat.
module mnist_seg_class_counter
    import mnist_seg_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 20
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           beat,
    input  logic                           sof,
    input  decode_t                        dec,
    output logic [CLASS_NUM*CNT_WIDTH-1:0] class_count,
    output logic                           count_valid
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt [CLASS_NUM];

    // On SOF the snapshot takes pre-beat values; the SOF beat seeds the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CLASS_NUM; i++) begin
                cnt[i] <= '0;
            end
            class_count <= '0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= beat && sof;
            if (beat) begin
                for (int i = 0; i < CLASS_NUM; i++) begin
                    if (sof) begin
                        class_count[i*CNT_WIDTH +: CNT_WIDTH] <= cnt[i];
                        cnt[i] <= (dec.hit && dec.cls == class_t'(i)) ? CNT_WIDTH'(1) : '0;
                    end else if (dec.hit && dec.cls == class_t'(i) && cnt[i] != CNT_MAX) begin
                        cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mnist_seg_colmap.sv
// Two-stage decode/colour pipeline turning segmentation results into an RGB overlay stream.
module mnist_seg_colmap
    import mnist_seg_pkg::*;
#(
    parameter int unsigned TUSER_WIDTH   = 1,
    parameter int unsigned S_TDATA_WIDTH = 11,
    parameter int unsigned CNT_WIDTH     = 20,
    parameter logic [23:0] BG_COLOR      = 24'h000000,
    parameter logic [23:0] AMBIG_COLOR   = 24'h808080
) (
    input  logic                           aresetn,
    input  logic                           aclk,
    input  logic [TUSER_WIDTH-1:0]         s_axi4s_tuser,
    input  logic                           s_axi4s_tlast,
    input  logic [S_TDATA_WIDTH-1:0]       s_axi4s_tdata,
    input  logic                           s_axi4s_tvalid,
    output logic                           s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]         m_axi4s_tuser,
    output logic                           m_axi4s_tlast,
    output logic [23:0]                    m_axi4s_tdata,
    output logic                           m_axi4s_tvalid,
    input  logic                           m_axi4s_tready,
    output logic [CLASS_NUM*CNT_WIDTH-1:0] class_count,
    output logic                           count_valid
);

    logic                   s1_valid;
    logic                   s1_fg;
    decode_t                s1_dec;
    logic [TUSER_WIDTH-1:0] s1_tuser;
    logic                   s1_tlast;

    logic                   s1_adv;
    logic                   s2_adv;
    logic                   in_acc;
    decode_t                in_dec;
    logic [23:0]            s1_rgb;

    assign in_dec = class_decode(s_axi4s_tdata[0], s_axi4s_tdata[CLASS_NUM:1]);

    // Ready ripples back combinationally from the output through both stages.
    assign s2_adv         = !m_axi4s_tvalid || m_axi4s_tready;
    assign s1_adv         = !s1_valid || s2_adv;
    assign s_axi4s_tready = aresetn && s1_adv;
    assign in_acc         = s_axi4s_tvalid && s_axi4s_tready;

    // Stage 1: decode register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid <= 1'b0;
            s1_fg    <= 1'b0;
            s1_dec   <= '0;
            s1_tuser <= '0;
            s1_tlast <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= s_axi4s_tvalid;
            if (s_axi4s_tvalid) begin
                s1_fg    <= s_axi4s_tdata[0];
                s1_dec   <= in_dec;
                s1_tuser <= s_axi4s_tuser;
                s1_tlast <= s_axi4s_tlast;
            end
        end
    end

    always_comb begin
        s1_rgb = BG_COLOR;
        if (s1_fg) begin
            s1_rgb = s1_dec.hit ? PALETTE[s1_dec.cls] : AMBIG_COLOR;
        end
    end

    // Stage 2: colour register driving the output stream.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axi4s_tvalid <= 1'b0;
            m_axi4s_tdata  <= '0;
            m_axi4s_tuser  <= '0;
            m_axi4s_tlast  <= 1'b0;
        end else if (s2_adv) begin
            m_axi4s_tvalid <= s1_valid;
            if (s1_valid) begin
                m_axi4s_tdata <= s1_rgb;
                m_axi4s_tuser <= s1_tuser;
                m_axi4s_tlast <= s1_tlast;
            end
        end
    end

    mnist_seg_class_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .clk         (aclk),
        .rst_n       (aresetn),
        .beat        (in_acc),
        .sof         (s_axi4s_tuser[0]),
        .dec         (in_dec),
        .class_count (class_count),
        .count_valid (count_valid)
    );

endmodule
